// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter:
//   ARB_RR / ARB_FIXED  arbitration mode selectors
//   TAG_ID_W            channel-id width carried inside a read tag
//   rd_tag_t            one stage of the read-tag pipeline {valid, ch_id}
//   ch_id_width()       encoded channel-index width, never less than 1 bit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Tags carry a fixed-width id so the struct needs no parameter; this covers
  // up to 256 channels. The unused upper bits of ch_id are always zero.
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] ch_id;
  } rd_tag_t;

  function automatic int ch_id_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational N-way arbiter with a registered round-robin pointer.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req   [NUM_CH]  request vector
//   advance         the current grant is consumed; lets the pointer move
//   gnt   [NUM_CH]  one-hot grant (all zero when req is zero)
//   gnt_idx         encoded index of the granted channel (0 when none)
// ARB_MODE = ARB_RR: the search starts at the pointer; after a grant to
// channel i the pointer becomes (i+1) mod NUM_CH.
// ARB_MODE = ARB_FIXED: lowest index wins and no pointer exists.
// ---------------------------------------------------------------------------
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int IDX_W    = ch_id_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  if (ARB_MODE == ARB_FIXED) begin : g_fixed

    // Clock, reset and advance have no role without a pointer.
    logic unused_fixed;
    assign unused_fixed = &{1'b0, clk, reset, advance};

    logic found;

    always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (!found && req[k]) begin
          found   = 1'b1;
          gnt[k]  = 1'b1;
          gnt_idx = IDX_W'(k);
        end
      end
    end

  end else begin : g_rr

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               cand;

    always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      // Walk the channels starting at the pointer, wrapping around once.
      for (int k = 0; k < NUM_CH; k++) begin
        cand = (int'(ptr_q) + k) % NUM_CH;
        if (!found && req[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          gnt_idx   = IDX_W'(cand);
        end
      end

      // The pointer only moves on an actual grant, so idle cycles leave it put.
      ptr_d = ptr_q;
      if (advance && found) begin
        ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= ptr_d;
      end
    end

  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between NUM_CH requesters.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req/reqWrite        per-channel request and direction (1 = write)
//   reqAddress/reqData  flattened per-channel fields, channel i at
//                       [i*W +: W]; held by the requester until gnt
//   gnt                 one-hot combinational grant, same cycle as req
//   rspValid/rspData    registered one-hot read-response strobe and data
//   address, dataToMemory, writeEnable   registered memory command
//   dataFromMemory      memory read data, MEM_LATENCY cycles after address
// A grant in cycle T puts the command on the memory bus in T+1. Reads push
// a {valid, ch_id} tag into a MEM_LATENCY+1 deep shift register; when the
// tag leaves, dataFromMemory is captured and rspValid fires in T+2+LATENCY.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        reqWrite,
  input  logic [NUM_CH*ADDR_W-1:0] reqAddress,
  input  logic [NUM_CH*DATA_W-1:0] reqData,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rspValid,
  output logic [DATA_W-1:0]        rspData,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        dataToMemory,
  output logic                     writeEnable,
  input  logic [DATA_W-1:0]        dataFromMemory
);

  localparam int IDX_W = ch_id_width(NUM_CH);

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] gnt_idx;
  logic             any_gnt;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE),
    .IDX_W    (IDX_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (1'b1),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt = |gnt;

  // -------------------------------------------------------------------------
  // Winner field selection: unpack the flattened buses, then AND-OR mux on
  // the one-hot grant (no index range concerns for non-power-of-2 NUM_CH).
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_addr[gi] = reqAddress[gi*ADDR_W +: ADDR_W];
    assign ch_data[gi] = reqData[gi*DATA_W +: DATA_W];
  end

  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_write;

  always_comb begin
    win_addr  = '0;
    win_data  = '0;
    win_write = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        win_addr  = win_addr | ch_addr[i];
        win_data  = win_data | ch_data[i];
        win_write = win_write | reqWrite[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Memory command registers
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_to_mem_q, data_to_mem_d;
  logic              write_enable_q, write_enable_d;

  always_comb begin
    // Address and write data hold across idle cycles; only the strobe drops.
    address_d      = any_gnt ? win_addr : address_q;
    data_to_mem_d  = any_gnt ? win_data : data_to_mem_q;
    write_enable_d = any_gnt & win_write;
  end

  // -------------------------------------------------------------------------
  // Read tag pipeline and response capture
  // -------------------------------------------------------------------------
  rd_tag_t           tag_q [MEM_LATENCY+1];
  rd_tag_t           tag_d [MEM_LATENCY+1];
  rd_tag_t           tag_exit;
  logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  assign tag_exit = tag_q[MEM_LATENCY];

  always_comb begin
    tag_d[0].valid = any_gnt & ~win_write;
    tag_d[0].ch_id = TAG_ID_W'(gnt_idx);
    for (int s = 1; s <= MEM_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end

    // The tag leaves in the cycle dataFromMemory holds its read data.
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rsp_valid_d[i] = tag_exit.valid && (tag_exit.ch_id == TAG_ID_W'(i));
    end
    rsp_data_d = tag_exit.valid ? dataFromMemory : rsp_data_q;
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q      <= '0;
      data_to_mem_q  <= '0;
      write_enable_q <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      for (int s = 0; s <= MEM_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      address_q      <= address_d;
      data_to_mem_q  <= data_to_mem_d;
      write_enable_q <= write_enable_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      for (int s = 0; s <= MEM_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign address      = address_q;
  assign dataToMemory = data_to_mem_q;
  assign writeEnable  = write_enable_q;
  assign rspValid     = rsp_valid_q;
  assign rspData      = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench: a round-robin instance drives a synchronous RAM model
// (one cycle read latency); a fixed-priority instance shares the request
// inputs so its grants can be compared on the same stimulus.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NUM_CH      = 4;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int MEM_LATENCY = 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        reqWrite;
  logic [NUM_CH*ADDR_W-1:0] reqAddress;
  logic [NUM_CH*DATA_W-1:0] reqData;
  logic [NUM_CH-1:0]        gnt, rspValid;
  logic [DATA_W-1:0]        rspData;
  logic [ADDR_W-1:0]        address;
  logic [DATA_W-1:0]        dataToMemory;
  logic                     writeEnable;
  logic [DATA_W-1:0]        dataFromMemory;

  logic [NUM_CH-1:0]        gnt_fp, rspValid_fp;
  logic [DATA_W-1:0]        rspData_fp;
  logic [ADDR_W-1:0]        address_fp;
  logic [DATA_W-1:0]        dataToMemory_fp;
  logic                     writeEnable_fp;

  logic unused_fp;
  assign unused_fp = ^{rspData_fp, address_fp, dataToMemory_fp, writeEnable_fp};

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_LATENCY(MEM_LATENCY), .ARB_MODE(0)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqData(reqData), .gnt(gnt),
    .rspValid(rspValid), .rspData(rspData), .address(address),
    .dataToMemory(dataToMemory), .writeEnable(writeEnable),
    .dataFromMemory(dataFromMemory)
  );

  mem_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_LATENCY(MEM_LATENCY), .ARB_MODE(1)
  ) dut_fp (
    .clk(clk), .reset(reset), .req(req), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqData(reqData), .gnt(gnt_fp),
    .rspValid(rspValid_fp), .rspData(rspData_fp), .address(address_fp),
    .dataToMemory(dataToMemory_fp), .writeEnable(writeEnable_fp),
    .dataFromMemory(dataFromMemory)
  );

  // Synchronous RAM, read-before-write. Contents are 0x1000+addr except
  // 0x10 which holds 0xBEEF; reloaded whenever reset is high at an edge.
  logic [DATA_W-1:0] ram [65536];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        ram[i] <= (i == 16'h0010) ? 16'hBEEF : 16'(16'h1000 + i);
      end
    end else if (writeEnable) begin
      ram[address] <= dataToMemory;
    end
    dataFromMemory <= ram[address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %-10s got=%h expected=%h @%0t", tag, got, exp, $time);
    end else begin
      $display("  ok %-10s = %h @%0t", tag, got, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic [15:0] a, input logic [15:0] d);
    reqWrite[ch]              = wr;
    reqAddress[ch*ADDR_W +: ADDR_W] = a;
    reqData[ch*DATA_W +: DATA_W]    = d;
  endtask

  int seq_ch [3] = '{3, 0, 1};

  initial begin
    reset      = 1'b1;
    req        = '0;
    reqWrite   = '0;
    reqAddress = '0;
    reqData    = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_addr", address, 16'h0000);
    chk("rst_dout", dataToMemory, 16'h0000);
    chk("rst_we", writeEnable, 1'b0);
    chk("rst_rspv", rspValid, 4'b0000);
    chk("rst_rspd", rspData, 16'h0000);

    // Round-robin fairness: all four read for 8 cycles, pointer starts at 0.
    for (int ch = 0; ch < 4; ch++) set_ch(ch, 1'b0, 16'(16'h0020 + ch), 16'h0000);
    for (int c = 0; c < 12; c++) begin
      req = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        chk("rr_gnt", gnt, 32'(1) << (c % 4));
        chk("fp_gnt", gnt_fp, 4'b0001);
      end else begin
        chk("idle_gnt", gnt, 4'b0000);
      end
      if (c >= 3 && c < 11) begin
        chk("rr_rspv", rspValid, 32'(1) << ((c - 3) % 4));
        chk("rr_rspd", rspData, 32'(16'h1020 + (c - 3) % 4));
        chk("fp_rspv", rspValid_fp, 4'b0001);
      end else begin
        chk("rr_rspv0", rspValid, 4'b0000);
      end
      tick();
    end

    // Single read: ch2 reads 0x0010 (0xBEEF). Pointer is back at 0.
    set_ch(2, 1'b0, 16'h0010, 16'h0000);
    req = 4'b0100;
    #1 chk("rd_gnt", gnt, 4'b0100);
    tick();
    req = 4'b0000;
    #1 chk("rd_addr", address, 16'h0010);
    chk("rd_we", writeEnable, 1'b0);
    chk("rd_rspv1", rspValid, 4'b0000);
    tick(); #1 chk("rd_rspv2", rspValid, 4'b0000);
    tick(); #1 chk("rd_rspv3", rspValid, 4'b0100);
    chk("rd_rspd", rspData, 16'hBEEF);
    tick(); #1 chk("rd_rspv4", rspValid, 4'b0000);

    // Write pulse: ch1 writes 0xA5A5 to 0x0003. Pointer is 3, so ch1 wins.
    set_ch(1, 1'b1, 16'h0003, 16'hA5A5);
    tick();
    req = 4'b0010;
    #1 chk("wr_gnt", gnt, 4'b0010);
    tick();
    req = 4'b0000;
    #1 chk("wr_we", writeEnable, 1'b1);
    chk("wr_dout", dataToMemory, 16'hA5A5);
    chk("wr_addr", address, 16'h0003);
    // Idle hold for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      tick();
      #1 chk("idle_gnt", gnt, 4'b0000);
      chk("idle_we", writeEnable, 1'b0);
      chk("idle_addr", address, 16'h0003);
      chk("idle_dout", dataToMemory, 16'hA5A5);
    end

    // Pointer held at 2 across the idle: all request, ch2 wins; reads 0x0003.
    for (int ch = 0; ch < 4; ch++) set_ch(ch, 1'b0, 16'h0003, 16'h0000);
    tick();
    req = 4'hF;
    #1 chk("ptr_gnt", gnt, 4'b0100);
    tick();
    req = 4'h0;
    tick(); tick();
    #1 chk("wb_rspv", rspValid, 4'b0100);
    chk("wb_rspd", rspData, 16'hA5A5);

    // Back-to-back reads: ch3, ch0, ch1 (pointer now 3).
    set_ch(3, 1'b0, 16'h0030, 16'h0000);
    set_ch(0, 1'b0, 16'h0031, 16'h0000);
    set_ch(1, 1'b0, 16'h0032, 16'h0000);
    tick();
    for (int c = 0; c < 7; c++) begin
      req = (c < 3) ? 4'(4'b0001 << seq_ch[c]) : 4'b0000;
      #1;
      if (c < 3) chk("b2b_gnt", gnt, 32'(1) << seq_ch[c]);
      if (c >= 3 && c < 6) begin
        chk("b2b_rspv", rspValid, 32'(1) << seq_ch[c-3]);
        chk("b2b_rspd", rspData, 32'(16'h1030 + c - 3));
      end else if (c == 6) begin
        chk("b2b_rspv0", rspValid, 4'b0000);
      end
      tick();
    end

    // Reset mid-stream with two reads in flight (pointer 2 -> ch0 then ch1).
    set_ch(0, 1'b0, 16'h0005, 16'h0000);
    set_ch(1, 1'b0, 16'h0006, 16'h0000);
    req = 4'b0001;
    #1 chk("inf_gnt0", gnt, 4'b0001);
    tick();
    req = 4'b0010;
    #1 chk("inf_gnt1", gnt, 4'b0010);
    tick();
    req = 4'b0000;
    #1 reset = 1'b1;
    #1 chk("arst_addr", address, 16'h0000);
    chk("arst_dout", dataToMemory, 16'h0000);
    chk("arst_we", writeEnable, 1'b0);
    chk("arst_rspv", rspValid, 4'b0000);
    chk("arst_rspd", rspData, 16'h0000);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk("post_rspv", rspValid, 4'b0000);
      tick();
    end
    req = 4'hF;
    #1 chk("post_gnt", gnt, 4'b0001);
    chk("post_fpgnt", gnt_fp, 4'b0001);
    tick();
    req = 4'h0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
